// File: rtl/div_issue_if.sv
// Handshake bundle for the divider issue stage: operand input, divider-side
// operands/result, and the result output register.
interface div_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;

  logic        div_run;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_divzero;
  logic        out_timeout;

  logic        busy;

  // slave: the issue stage itself
  modport slave (
    input  in_valid, in_dividend, in_divisor,
    output in_ready,
    output div_run, div_dividend, div_divisor,
    input  div_ready, div_quotient, div_remainder,
    output out_valid, out_quotient, out_remainder, out_divzero, out_timeout,
    input  out_ready,
    output busy
  );

  // master: producer, divider and consumer around the issue stage
  modport master (
    output in_valid, in_dividend, in_divisor,
    input  in_ready,
    input  div_run, div_dividend, div_divisor,
    output div_ready, div_quotient, div_remainder,
    input  out_valid, out_quotient, out_remainder, out_divzero, out_timeout,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/div_issue.sv
// Issue stage for a 32-bit sequential divider: operand FIFO, run/wait FSM with
// watchdog, local divide-by-zero resolution and a handshaked result register.
module div_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  div_issue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECOVER} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wdog, wdog_nx;

  logic [31:0]     mem_a [DEPTH];
  logic [31:0]     mem_b [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            push, pop, latch;
  logic [31:0]     head_a, head_b;

  logic [31:0]     dd_q, dv_q;
  logic            out_v, out_dz, out_to;
  logic [31:0]     out_q, out_r;

  logic            ld, ld_dz, ld_to;
  logic [31:0]     ld_q, ld_r;
  logic            slot_free;

  // in_ready is a pure function of count, so out_ready never reaches it
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign head_a       = mem_a[rptr];
  assign head_b       = mem_b[rptr];
  assign slot_free    = ~out_v | bus.out_ready;

  assign bus.div_run       = (state == ISSUE);
  assign bus.div_dividend  = dd_q;
  assign bus.div_divisor   = dv_q;
  assign bus.out_valid     = out_v;
  assign bus.out_quotient  = out_q;
  assign bus.out_remainder = out_r;
  assign bus.out_divzero   = out_dz;
  assign bus.out_timeout   = out_to;
  assign bus.busy          = (count != '0) | (state != IDLE) | out_v;

  always_comb begin
    state_nx = state;
    wdog_nx  = wdog;
    pop      = 1'b0;
    latch    = 1'b0;
    ld       = 1'b0;
    ld_q     = '0;
    ld_r     = '0;
    ld_dz    = 1'b0;
    ld_to    = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && slot_free) begin
          pop = 1'b1;
          if (head_b == '0) begin
            ld    = 1'b1;
            ld_q  = '1;
            ld_r  = head_a;
            ld_dz = 1'b1;
          end else begin
            latch    = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_nx  = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (bus.div_ready) begin
          ld       = 1'b1;
          ld_q     = bus.div_quotient;
          ld_r     = bus.div_remainder;
          state_nx = RECOVER;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          ld       = 1'b1;
          ld_to    = 1'b1;
          state_nx = RECOVER;
        end else begin
          wdog_nx = wdog + 1'b1;
        end
      end
      RECOVER: begin
        // a level-held ready must drop before the next issue can see it
        if (!bus.div_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // storage only; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= bus.in_dividend;
      mem_b[wptr] <= bus.in_divisor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wdog   <= '0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      dd_q   <= '0;
      dv_q   <= '0;
      out_v  <= 1'b0;
      out_q  <= '0;
      out_r  <= '0;
      out_dz <= 1'b0;
      out_to <= 1'b0;
    end else begin
      state <= state_nx;
      wdog  <= wdog_nx;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (latch) begin
        dd_q <= head_a;
        dv_q <= head_b;
      end
      if (ld) begin
        out_v  <= 1'b1;
        out_q  <= ld_q;
        out_r  <= ld_r;
        out_dz <= ld_dz;
        out_to <= ld_to;
      end else if (out_v && bus.out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue: behavioural divider, scoreboard of expected
// results, and checks on run pulses, backpressure, watchdog and reset.
module tb_div_issue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_issue_if bus();

  div_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        to;
  } res_t;

  res_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   res_cnt = 0;

  // divider model knobs
  int   dv_lat = 3;
  int   dv_hold = 1;
  bit   never = 1'b0;
  int   runs = 0;
  int   cnt, hold_c;
  bit   m_busy;
  logic [31:0] m_a, m_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic res_t mk(input logic [31:0] a, input logic [31:0] b);
    res_t e;
    if (b == 32'd0) e = '{q: 32'hFFFF_FFFF, r: a, dz: 1'b1, to: 1'b0};
    else            e = '{q: a / b, r: a % b, dz: 1'b0, to: 1'b0};
    return e;
  endfunction

  // behavioural divider: fixed latency, ready held dv_hold cycles
  always @(posedge clk) begin
    if (!rst) begin
      bus.div_ready     <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
      m_busy <= 1'b0;
      cnt    <= 0;
      hold_c <= 0;
    end else if (bus.div_run) begin
      runs   <= runs + 1;
      m_busy <= !never;
      cnt    <= dv_lat;
      m_a    <= bus.div_dividend;
      m_b    <= bus.div_divisor;
    end else if (m_busy) begin
      if (cnt > 1) cnt <= cnt - 1;
      else begin
        m_busy            <= 1'b0;
        bus.div_ready     <= 1'b1;
        hold_c            <= dv_hold;
        bus.div_quotient  <= (m_b == 0) ? 32'd0 : m_a / m_b;
        bus.div_remainder <= (m_b == 0) ? 32'd0 : m_a % m_b;
      end
    end else if (bus.div_ready) begin
      if (hold_c > 1) hold_c <= hold_c - 1;
      else bus.div_ready <= 1'b0;
    end
  end

  // scoreboard and hold monitor
  bit   held = 1'b0;
  res_t held_v, cur, e;
  always @(negedge clk) begin
    if (!rst) held = 1'b0;
    else begin
      cur = '{q: bus.out_quotient, r: bus.out_remainder, dz: bus.out_divzero, to: bus.out_timeout};
      if (bus.div_run) chk("run_while_ready", bus.div_ready, 1'b0);
      if (held) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", {30'd0, cur}, {30'd0, held_v});
      end
      if (bus.out_valid && bus.out_ready) begin
        res_cnt++;
        chk("result_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_quotient", cur.q, e.q);
          chk("out_remainder", cur.r, e.r);
          chk("out_flags", {cur.dz, cur.to}, {e.dz, e.to});
        end
      end
      held   = bus.out_valid && !bus.out_ready;
      held_v = cur;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t ex);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1'b1);
    @(posedge clk);
    sb.push_back(ex);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   r0, c0, lat, nw;
    res_t to_res;
    to_res = '{q: 32'd0, r: 32'd0, dz: 1'b0, to: 1'b1};

    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    // reset state
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_div_run", bus.div_run, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", {bus.out_quotient, bus.out_remainder}, 64'd0);
    chk("rst_out_flags", {bus.out_divzero, bus.out_timeout}, 2'b00);
    chk("rst_div_ops", {bus.div_dividend, bus.div_divisor}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick(1);

    // 100/7: one run pulse, exactly in cycle E+1
    bus.out_ready = 1'b1;
    dv_lat = 3;
    r0 = runs;
    send(32'd100, 32'd7, mk(32'd100, 32'd7));
    @(negedge clk); chk("run_early", bus.div_run, 1'b0);
    @(negedge clk); chk("run_pulse", bus.div_run, 1'b1);
    chk("run_operands", {bus.div_dividend, bus.div_divisor}, {32'd100, 32'd7});
    @(negedge clk); chk("run_single", bus.div_run, 1'b0);
    drain(50);
    tick(3);
    chk("runs_100_7", runs - r0, 1);

    // 5/0 resolved locally
    r0 = runs;
    send(32'd5, 32'd0, mk(32'd5, 32'd0));
    @(negedge clk); chk("dz_not_yet", bus.out_valid, 1'b0);
    @(negedge clk); chk("dz_valid", bus.out_valid, 1'b1);
    chk("dz_data", {bus.out_quotient, bus.out_remainder}, {32'hFFFF_FFFF, 32'd5});
    chk("dz_flag", bus.out_divzero, 1'b1);
    tick(3);
    chk("dz_no_run", runs - r0, 0);

    // backpressure: 5 pairs while consumer stalls
    bus.out_ready = 1'b0;
    dv_lat = 2;
    for (int i = 0; i < 5; i++)
      send(32'd200 + 32'(i) * 32'd13, 32'd3 + 32'(i), mk(32'd200 + 32'(i) * 32'd13, 32'd3 + 32'(i)));
    tick(4);
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_out_valid", bus.out_valid, 1'b1);
    chk("full_busy", bus.busy, 1'b1);
    tick(3);
    chk("full_still", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    drain(200);

    // level-held ready: one capture per issue
    dv_hold = 3;
    r0 = runs;
    c0 = res_cnt;
    send(32'd1000, 32'd9, mk(32'd1000, 32'd9));
    send(32'hFFFF_FFFF, 32'd16, mk(32'hFFFF_FFFF, 32'd16));
    drain(100);
    tick(6);
    chk("hold_runs", runs - r0, 2);
    chk("hold_results", res_cnt - c0, 2);
    dv_hold = 1;

    // watchdog abort, then the queued entry proceeds
    never = 1'b1;
    r0 = runs;
    send(32'd77, 32'd5, to_res);
    nw = 0;
    while (!bus.div_run && nw < 20) begin @(negedge clk); nw++; end
    chk("to_run", bus.div_run, 1'b1);
    bus.in_valid = 1'b1; bus.in_dividend = 32'd60; bus.in_divisor = 32'd7;
    @(posedge clk);
    sb.push_back(mk(32'd60, 32'd7));
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("to_latency", lat, TIMEOUT + 1);
    chk("to_flag", bus.out_timeout, 1'b1);
    never = 1'b0;
    drain(100);
    chk("to_runs", runs - r0, 2);

    // async reset while waiting with two entries queued
    never = 1'b1;
    send(32'd11, 32'd2, to_res);
    send(32'd12, 32'd3, mk(32'd12, 32'd3));
    send(32'd13, 32'd4, mk(32'd13, 32'd4));
    tick(4);
    chk("pre_rst_busy", bus.busy, 1'b1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_div_ops", {bus.div_dividend, bus.div_divisor}, 64'd0);
    chk("arst_div_run", bus.div_run, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    r0 = runs;
    rst = 1'b1;
    never = 1'b0;
    tick(10);
    chk("post_rst_runs", runs - r0, 0);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // normal operation resumes
    send(32'd81, 32'd9, mk(32'd81, 32'd9));
    drain(50);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
